im_loader: RTL and testbench

Boot-time instruction-memory writer: the write-side counterpart of the fetch stage's instruction-memory read port. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them sequentially into the word-addressed instruction memory. It holds the core in `cpu_hold` until a complete, checksum-verified image is loaded. It sits between the host byte link (e.g. UART receiver) and the IM write port; `cpu_hold` gates the PC/fetch logic.

---
 rtl/im_loader.sv | 141 ++++++++++++++
 tb/tb_im_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed, checksummed byte
// stream and writes big-endian 32-bit words to sequential IM word addresses.
module im_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state, state_next;
  logic        xfer;
  logic        restart;
  logic        last_word;
  logic [15:0] len_now;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic [7:0]  sum;

  assign xfer      = byte_valid && byte_ready;
  assign len_now   = {len_hi, byte_data};
  // word_count equals the address of the word being assembled
  assign last_word = (16'(word_count) + 16'd1) == len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    restart    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_next = S_LEN_HI;
        restart    = 1'b1;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if ({1'b0, len_now} > MAX_LEN) state_next = S_ERR;
          else if (len_now == 16'd0)     state_next = S_CHK;
          else                           state_next = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_cnt == 2'd3 && last_word) state_next = S_CHK;
      end
      S_CHK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = (byte_data == sum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) begin
          state_next = S_LEN_HI;
          restart    = 1'b1;
        end
      end
      S_ERR: begin
        err = 1'b1;
        if (start) begin
          state_next = S_LEN_HI;
          restart    = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_we      <= 1'b0;
      im_waddr   <= '0;
      im_wdata   <= '0;
      word_count <= '0;
      len_hi     <= '0;
      len        <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      sum        <= '0;
    end else begin
      im_we <= 1'b0;
      if (restart) begin
        word_count <= '0;
        byte_cnt   <= '0;
        asm_q      <= '0;
        sum        <= '0;
      end else if (xfer) begin
        case (state)
          S_LEN_HI: len_hi <= byte_data;
          S_LEN_LO: len    <= len_now;
          S_DATA: begin
            sum      <= sum + byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {asm_q[15:0], byte_data};
            if (byte_cnt == 2'd3) begin
              im_we      <= 1'b1;
              im_waddr   <= word_count[ADDR_W-1:0];
              im_wdata   <= {asm_q, byte_data};
              word_count <= word_count + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: stimulus queues expected IM writes, a monitor
// pops and compares each im_we pulse; end-of-frame status is checked directly.
module tb_im_loader;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   word_count;
  logic              cpu_hold;
  logic              done;
  logic              err;

  im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .im_we(im_we),
    .im_waddr(im_waddr), .im_wdata(im_wdata), .word_count(word_count),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_exp;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] img [0:1] = '{32'h12345678, 32'h9ABCDEF0};

  // Payload sum: 0x12+0x34+0x56+0x78+0x9A+0xBC+0xDE+0xF0 = 0x438 -> 0x38
  localparam logic [7:0] GOOD_CHK = 8'h38;
  localparam logic [7:0] BAD_CHK  = 8'h39;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst && im_we) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%h, expected no write", im_waddr, im_wdata);
      end else begin
        mon_exp = sb.pop_front();
        check("wr_addr", 32'(im_waddr), 32'(mon_exp.addr));
        check("wr_data", im_wdata, mon_exp.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps && $urandom_range(0, 1) == 1) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: byte_ready=0, expected 1");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input bit gaps);
    sb.push_back('{addr: addr, data: w});
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gaps);
  endtask

  task automatic send_frame(input logic [15:0] n, input bit gaps, input logic [7:0] chk);
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    for (int k = 0; k < int'(n); k++) send_word(ADDR_W'(k), img[k], gaps);
    send_byte(chk, gaps);
    byte_valid = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hold"},  32'(cpu_hold),   32'd1);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"},    32'(im_we),      32'd0);
    check({tag, "_waddr"}, 32'(im_waddr),   32'd0);
    check({tag, "_wdata"}, im_wdata,        32'd0);
    check({tag, "_wc"},    32'(word_count), 32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
  endtask

  task automatic check_result(input string tag, input bit exp_done, input bit exp_err,
                              input int exp_wc);
    check({tag, "_done"}, 32'(done),       32'(exp_done));
    check({tag, "_err"},  32'(err),        32'(exp_err));
    check({tag, "_hold"}, 32'(cpu_hold),   32'(!exp_done));
    check({tag, "_wc"},   32'(word_count), 32'(exp_wc));
    check({tag, "_sb"},   32'(sb.size()),  32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b1;
    @(negedge clk);

    // Idle: valid without start never transfers
    repeat (3) begin
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      @(negedge clk);
      check("idle_ready", 32'(byte_ready), 32'd0);
      byte_valid = 1'b0;
      @(negedge clk);
    end
    check_reset("idle");

    // Good frame, one byte per cycle; done must be up right after the checksum edge
    start_load();
    send_frame(16'd2, 1'b0, GOOD_CHK);
    check_result("good", 1'b1, 1'b0, 2);

    // Restart from DONE raises cpu_hold on the next edge, then a gapped stream
    start_load();
    check("restart_hold", 32'(cpu_hold), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_wc", 32'(word_count), 32'd0);
    send_frame(16'd2, 1'b1, GOOD_CHK);
    check_result("gaps", 1'b1, 1'b0, 2);

    // Bad checksum: both words written, error, core stays held
    start_load();
    send_frame(16'd2, 1'b0, BAD_CHK);
    check_result("badchk", 1'b0, 1'b1, 2);
    repeat (2) @(negedge clk);
    check("badchk_hold_stays", 32'(cpu_hold), 32'd1);
    start_load();
    send_frame(16'd2, 1'b0, GOOD_CHK);
    check_result("recover", 1'b1, 1'b0, 2);

    // Oversized length: error straight after LEN_LO, nothing written
    start_load();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    byte_valid = 1'b0;
    check("overlen_err", 32'(err), 32'd1);
    check("overlen_ready", 32'(byte_ready), 32'd0);
    repeat (6) @(negedge clk);
    check_result("overlen", 1'b0, 1'b1, 0);

    // Empty image
    start_load();
    send_frame(16'd0, 1'b0, 8'h00);
    check_result("zero", 1'b1, 1'b0, 0);

    // Reset after 6 payload bytes, then a full load from address 0
    start_load();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word('0, img[0], 1'b0);
    send_byte(8'h9A, 1'b0);
    send_byte(8'hBC, 1'b0);
    byte_valid = 1'b0;
    check("midload_hold", 32'(cpu_hold), 32'd1);
    rst = 1'b0;
    #1;
    check_reset("midrst");
    check("midrst_sb", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_load();
    send_frame(16'd2, 1'b0, GOOD_CHK);
    check_result("after_rst", 1'b1, 1'b0, 2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
